// File: rtl/video_stream_upscaler_if.sv
// Avalon-ST pixel stream bundle shared by the upscaler sink and source.
//   data          pixel payload
//   valid         payload present this cycle
//   startofpacket first pixel of a frame
//   endofpacket   last pixel of a frame
//   ready         consumer accepts the payload this cycle
// The master modport drives the payload; the slave modport drives ready.
interface video_stream_upscaler_if #(
  parameter int DATA_W = 30
) ();
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              startofpacket;
  logic              endofpacket;
  logic              ready;

  modport master (output data, valid, startofpacket, endofpacket, input ready);
  modport slave  (input data, valid, startofpacket, endofpacket, output ready);
endinterface

// File: rtl/video_stream_upscaler.sv
// Integer video upscaler (1..4 horizontally and vertically).
// Each input line is streamed out live while being written to a line buffer,
// then replayed from the buffer for the remaining vertical repeats.
// Ports:
//   clk_clk        single clock
//   reset_reset_n  asynchronous active-low reset
//   scale_x        horizontal factor minus one, latched at frame start
//   scale_y        vertical factor minus one, latched at frame start
//   sink           input pixel stream (slave)
//   source         output pixel stream (master)
//   frame_error    one-cycle pulse when SOP/EOP disagree with frame geometry
//   busy           high from SOP acceptance until the last output pixel leaves
module video_stream_upscaler #(
  parameter int DATA_W = 30,
  parameter int IN_W   = 320,
  parameter int IN_H   = 240
) (
  input  logic                           clk_clk,
  input  logic                           reset_reset_n,
  input  logic [1:0]                     scale_x,
  input  logic [1:0]                     scale_y,
  video_stream_upscaler_if.slave         sink,
  video_stream_upscaler_if.master        source,
  output logic                           frame_error,
  output logic                           busy
);
  localparam int X_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int Y_W = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(IN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IN_H - 1);
  localparam logic [X_W-1:0] X_ONE  = (IN_W > 1) ? X_W'(1) : '0;

  typedef enum logic [1:0] {IDLE, LIVE, REPLAY} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        sx_m1_reg, sx_m1_next;
  logic [1:0]        sy_m1_reg, sy_m1_next;
  // input-side position of the next pixel to accept
  logic [X_W-1:0]    in_x_reg, in_x_next;
  logic [Y_W-1:0]    in_y_reg, in_y_next;
  // set once the current input line is complete and must not be followed yet
  logic              in_hold_reg, in_hold_next;
  // skid entry: lets sink_ready be registered without losing throughput
  logic              pend_valid_reg, pend_valid_next;
  logic [DATA_W-1:0] pend_data_reg, pend_data_next;
  logic [X_W-1:0]    pend_x_reg, pend_x_next;
  // output register and its position in the output frame
  logic              out_valid_reg, out_valid_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  logic [X_W-1:0]    out_x_reg, out_x_next;
  logic [1:0]        rep_x_reg, rep_x_next;
  logic [Y_W-1:0]    out_y_reg, out_y_next;
  logic [1:0]        rep_y_reg, rep_y_next;
  logic [X_W-1:0]    rd_x_reg, rd_x_next;
  logic              sink_ready_reg, sink_ready_next;
  logic              frame_error_reg, frame_error_next;

  // line buffer
  logic [DATA_W-1:0] line_mem [IN_W];
  logic [DATA_W-1:0] rd_data;
  logic              wr_en, rd_en;
  logic [X_W-1:0]    wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data;

  logic              src_fire, last_rep, out_free, line_done, frame_done;
  logic              sink_fire, accept, in_first, in_last, pix_err;
  logic [1:0]        sy_use;
  logic [X_W-1:0]    ld_x;

  assign src_fire   = out_valid_reg & source.ready;
  assign last_rep   = (rep_x_reg == sx_m1_reg);
  // output register can take a new pixel at the coming edge
  assign out_free   = ~out_valid_reg | (src_fire & last_rep);
  assign line_done  = src_fire & last_rep & (out_x_reg == X_LAST);
  assign frame_done = line_done & (out_y_reg == Y_LAST) & (rep_y_reg == sy_m1_reg);
  assign sink_fire  = sink.valid & sink_ready_reg;
  // in IDLE only an SOP pixel starts a frame; everything else is dropped
  assign accept     = sink_fire & ((state_reg == LIVE) |
                      ((state_reg == IDLE) & sink.startofpacket));
  assign sy_use     = (state_reg == IDLE) ? scale_y : sy_m1_reg;
  assign in_first   = (in_x_reg == '0) & (in_y_reg == '0);
  assign in_last    = (in_x_reg == X_LAST) & (in_y_reg == Y_LAST);
  assign pix_err    = (sink.endofpacket & ~in_last) | (~sink.endofpacket & in_last) |
                      (sink.startofpacket & ~in_first);
  // rd_x always points one past the pixel currently held in rd_data
  assign ld_x       = (rd_x_reg == '0) ? X_LAST : rd_x_reg - X_W'(1);

  always_comb begin
    state_next       = state_reg;
    sx_m1_next       = sx_m1_reg;
    sy_m1_next       = sy_m1_reg;
    in_x_next        = in_x_reg;
    in_y_next        = in_y_reg;
    in_hold_next     = in_hold_reg;
    pend_valid_next  = pend_valid_reg;
    pend_data_next   = pend_data_reg;
    pend_x_next      = pend_x_reg;
    out_valid_next   = out_valid_reg;
    out_data_next    = out_data_reg;
    out_x_next       = out_x_reg;
    rep_x_next       = rep_x_reg;
    out_y_next       = out_y_reg;
    rep_y_next       = rep_y_reg;
    rd_x_next        = rd_x_reg;
    sink_ready_next  = 1'b0;
    frame_error_next = 1'b0;
    wr_en            = 1'b0;
    wr_addr          = in_x_reg;
    wr_data          = sink.data;
    rd_en            = 1'b0;
    rd_addr          = rd_x_reg;

    // input side: buffer write, input position, framing checks
    if (accept) begin
      wr_en            = 1'b1;
      frame_error_next = pix_err;
      if (state_reg == IDLE) begin
        sx_m1_next = scale_x;
        sy_m1_next = scale_y;
        state_next = LIVE;
      end
      if (in_x_reg == X_LAST) begin
        in_x_next    = '0;
        in_y_next    = (in_y_reg == Y_LAST) ? '0 : in_y_reg + Y_W'(1);
        // stop input until the replays (or the whole frame) are done
        in_hold_next = (sy_use != 2'd0) | (in_y_reg == Y_LAST);
      end else begin
        in_x_next = in_x_reg + X_W'(1);
      end
    end

    // output side
    if (src_fire & ~last_rep) rep_x_next = rep_x_reg + 2'd1;

    if (state_reg == REPLAY) begin
      if (out_free) begin
        rep_x_next = 2'd0;
        if (line_done & (rep_y_reg == sy_m1_reg)) begin
          out_valid_next = 1'b0;
          rep_y_next     = 2'd0;
          out_y_next     = out_y_reg + Y_W'(1);
          in_hold_next   = 1'b0;
          state_next     = LIVE;
        end else begin
          if (line_done) rep_y_next = rep_y_reg + 2'd1;
          // take the prefetched pixel and fetch the next (wraps for the next repeat)
          out_valid_next = 1'b1;
          out_data_next  = rd_data;
          out_x_next     = ld_x;
          rd_en          = 1'b1;
          rd_x_next      = (rd_x_reg == X_LAST) ? '0 : rd_x_reg + X_W'(1);
        end
      end
    end else if (line_done & (sy_m1_reg != 2'd0)) begin
      // live line finished: start replay, first read costs one bubble
      state_next     = REPLAY;
      rep_y_next     = 2'd1;
      rep_x_next     = 2'd0;
      out_valid_next = 1'b0;
      rd_en          = 1'b1;
      rd_addr        = '0;
      rd_x_next      = X_ONE;
    end else if (out_free) begin
      if (line_done) out_y_next = out_y_reg + Y_W'(1);
      rep_x_next = 2'd0;
      if (pend_valid_reg) begin
        out_valid_next  = 1'b1;
        out_data_next   = pend_data_reg;
        out_x_next      = pend_x_reg;
        pend_valid_next = 1'b0;
      end else if (accept) begin
        out_valid_next = 1'b1;
        out_data_next  = sink.data;
        out_x_next     = in_x_reg;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (accept) begin
      // downstream stalled on the final repeat: park the pixel
      pend_valid_next = 1'b1;
      pend_data_next  = sink.data;
      pend_x_next     = in_x_reg;
    end

    if (frame_done) begin
      state_next      = IDLE;
      out_valid_next  = 1'b0;
      pend_valid_next = 1'b0;
      in_hold_next    = 1'b0;
      in_x_next       = '0;
      in_y_next       = '0;
      out_x_next      = '0;
      out_y_next      = '0;
      rep_x_next      = 2'd0;
      rep_y_next      = 2'd0;
      rd_x_next       = '0;
    end

    // registered ready: only promise a slot that is guaranteed to exist
    case (state_next)
      IDLE:    sink_ready_next = 1'b1;
      LIVE:    sink_ready_next = ~in_hold_next & ~pend_valid_next &
                                 (~out_valid_next | (rep_x_next == sx_m1_next));
      default: sink_ready_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg       <= IDLE;
      sx_m1_reg       <= 2'd0;
      sy_m1_reg       <= 2'd0;
      in_x_reg        <= '0;
      in_y_reg        <= '0;
      in_hold_reg     <= 1'b0;
      pend_valid_reg  <= 1'b0;
      pend_data_reg   <= '0;
      pend_x_reg      <= '0;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      out_x_reg       <= '0;
      rep_x_reg       <= 2'd0;
      out_y_reg       <= '0;
      rep_y_reg       <= 2'd0;
      rd_x_reg        <= '0;
      sink_ready_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      sx_m1_reg       <= sx_m1_next;
      sy_m1_reg       <= sy_m1_next;
      in_x_reg        <= in_x_next;
      in_y_reg        <= in_y_next;
      in_hold_reg     <= in_hold_next;
      pend_valid_reg  <= pend_valid_next;
      pend_data_reg   <= pend_data_next;
      pend_x_reg      <= pend_x_next;
      out_valid_reg   <= out_valid_next;
      out_data_reg    <= out_data_next;
      out_x_reg       <= out_x_next;
      rep_x_reg       <= rep_x_next;
      out_y_reg       <= out_y_next;
      rep_y_reg       <= rep_y_next;
      rd_x_reg        <= rd_x_next;
      sink_ready_reg  <= sink_ready_next;
      frame_error_reg <= frame_error_next;
    end
  end

  // line buffer: no reset so it maps onto block RAM
  always_ff @(posedge clk_clk) begin
    if (wr_en) line_mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= line_mem[rd_addr];
  end

  assign sink.ready           = sink_ready_reg;
  assign source.valid         = out_valid_reg;
  assign source.data          = out_data_reg;
  assign source.startofpacket = out_valid_reg & (out_y_reg == '0) & (rep_y_reg == 2'd0) &
                                (out_x_reg == '0) & (rep_x_reg == 2'd0);
  assign source.endofpacket   = out_valid_reg & (out_y_reg == Y_LAST) & (rep_y_reg == sy_m1_reg) &
                                (out_x_reg == X_LAST) & (rep_x_reg == sx_m1_reg);
  assign frame_error          = frame_error_reg;
  assign busy                 = (state_reg != IDLE);
endmodule

// File: doc/video_stream_upscaler.md
# video_stream_upscaler

Parametrised Avalon-ST integer video upscaler that sits between the camera pixel stream and the VGA controller sink. It replaces the fixed scaler stage. Pixel width, input frame geometry and line-buffer depth are parameters. Horizontal and vertical scale factors (1–4 each) are selected at run time, and frame-length errors are detected. Each input line is streamed live once while being written to an internal line buffer, then replayed from the buffer for the remaining vertical repeats.

## Interface
Parameters:
- DATA_W, 30, pixel width in bits (10:10:10 RGB by default)
- IN_W, 320, input pixels per line; also the line-buffer depth
- IN_H, 240, input lines per frame

Ports:
- clk_clk  in  1  single clock for the whole block
- reset_reset_n  in  1  asynchronous, active-low reset
- scale_x  in  2  horizontal factor SX = scale_x+1
- scale_y  in  2  vertical factor SY = scale_y+1
- sink_data  in  DATA_W  input pixel
- sink_valid  in  1  input pixel valid
- sink_startofpacket  in  1  first pixel of frame
- sink_endofpacket  in  1  last pixel of frame
- sink_ready  out  1  block accepts sink pixel this cycle
- source_data  out  DATA_W  output pixel
- source_valid  out  1  output pixel valid
- source_startofpacket  out  1  first output pixel of frame
- source_endofpacket  out  1  last output pixel of frame
- source_ready  in  1  downstream accepts pixel
- frame_error  out  1  one-cycle pulse on framing mismatch
- busy  out  1  high from SOP accept until the last output pixel is accepted

## Operation
- Reset values: sink_ready=0, source_valid=0, source_startofpacket=0, source_endofpacket=0, source_data=0, frame_error=0, busy=0. All counters are 0 and the FSM is in IDLE.
- Counters:
  - in_x: 0..IN_W-1
  - in_y: 0..IN_H-1
  - rep_x: 0..SX-1
  - rep_y: 0..SY-1
  - rd_x: line-buffer read address
- IDLE:
  - sink_ready=1.
  - Pixels without SOP are discarded.
  - A pixel with SOP is accepted. On acceptance: latch SX/SY from scale_x/scale_y, write the pixel to line buffer address 0, load it into the output register, and go to LIVE.
  - scale_x/scale_y are ignored for the rest of the frame.
- LIVE (rep_y=0):
  - Each accepted pixel is written to the buffer at address in_x and presented SX times on the source.
  - sink_ready=1 only when the output register is empty or being drained on its final repeat (rep_x=SX-1 and source_ready=1).
  - After pixel in_x=IN_W-1 completes: if SY=1, advance in_y and stay in LIVE; otherwise go to REPLAY with rep_y=1.
- REPLAY (rep_y=1..SY-1):
  - sink_ready=0.
  - Reads the buffer at addresses 0..IN_W-1; each pixel is presented SX times.
  - After the line completes: if rep_y=SY-1, advance in_y and return to LIVE; otherwise increment rep_y.
- Last input line:
  - When the last output pixel of line in_y=IN_H-1 (final rep_y, final rep_x) is accepted, go to IDLE. busy drops on the same edge.
- Output framing:
  - source_startofpacket=1 only on the first output pixel: in_y=0, rep_y=0, in_x=0, rep_x=0.
  - source_endofpacket=1 only on the last output pixel: in_y=IN_H-1, rep_y=SY-1, in_x=IN_W-1, rep_x=SX-1.
  - An output frame is (IN_W·SX)×(IN_H·SY) pixels.
- Frame errors:
  - Frame length is set by IN_W·IN_H. sink_endofpacket does not terminate the frame.
  - frame_error pulses for one cycle on acceptance of any of:
    - a pixel with EOP that is not the last pixel
    - the last pixel without EOP
    - a pixel with SOP that is not the first pixel
  - The pixel is used as ordinary data in all three cases.
- Line buffer: single-port-write, synchronous-read RAM of IN_W×DATA_W. Writes happen only in LIVE; reads only in REPLAY.

## Timing
- Source handshake:
  - A pixel transfers on any cycle with source_valid=1 and source_ready=1.
  - While source_valid=1 and source_ready=0, source_data, source_startofpacket and source_endofpacket hold stable.
- Sink handshake: a pixel transfers on any cycle with sink_valid=1 and sink_ready=1. sink_ready is a registered output.
- Latency:
  - Sink acceptance to source_valid: 1 cycle.
  - Sustained output with source_ready held high: 1 pixel/cycle in LIVE (sink stalled for SX-1 of every SX cycles) and in REPLAY.
- REPLAY entry: exactly one bubble cycle (source_valid=0) for the first RAM read. Buffer reads are prefetched so no further bubbles occur within the line.
- Simultaneous events: a last-repeat drain and a new sink accept in the same cycle give back-to-back output with no bubble.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronous). After release the block is in IDLE and waits for the next SOP; line-buffer contents are don't-care.

## Test plan
- IN_W=4, IN_H=2, scale 1×1, frame 0..7 with source_ready=1: output 0..7 at 1 pixel/cycle after 1-cycle latency, SOP on 0, EOP on 7, frame_error=0.
- IN_W=4, IN_H=2, SX=2, SY=3, pixels A0..A3/B0..B3:
  - Output is 48 pixels; each line is A0 A0 A1 A1 A2 A2 A3 A3, repeated 3 times, then the same for B.
  - One bubble at each REPLAY entry; EOP only on the 48th pixel.
- source_ready toggled randomly at 50% with 2×2 scaling: no pixel lost or duplicated beyond the scale factor, and data stays stable while stalled.
- Pixels before the first SOP: discarded and not output. Change scale_x mid-frame from 0 to 3: current frame keeps SX=1, and the next frame uses SX=4.
- EOP on pixel index 5 of 8, then no EOP on pixel 7: frame_error pulses twice, and the output frame is still complete and correct.
- Assert reset_reset_n=0 in the middle of REPLAY: all outputs go to 0 in the same cycle. After release, a new SOP frame is scaled correctly from its first pixel.
